sprite_motion_ctrl: RTL
=======================

// Module: sprite_motion_ctrl
// PURPOSE
//  Parametrised sprite motion controller for the VGA console. Turns the four button
//  inputs into a registered direction state and updates a registered sprite position
//  once every FRAME_DIV frames. Updates occur during the frame-end pixel (H_LAST, V_LAST),
//  so the position never changes mid-scan. Drives new_position_x/y and moveSprite of the
//  sprite printer; supersedes the hard-wired +/-1, Y-only movement logic.
// PARAMETERS
//  H_LAST     799  last active pixel_x of the frame (end-of-frame column)
//  V_LAST     599  last active pixel_y of the frame (end-of-frame row)
//  INIT_X     50   position X after reset
//  INIT_Y     300  position Y after reset
//  SPRITE_W   25   sprite width in pixels; SPRITE_H 25 sprite height in pixels
//  STEP       1    pixels moved per update (1..31)
//  FRAME_DIV  1    frames per update (1..255); 1 = update every frame
//  WRAP       0    0 = clamp at screen edges, 1 = wrap to opposite edge
// PORTS
//  clk          in   1   system clock
//  reset        in   1   asynchronous, active-low reset
//  left         in   1   button, level, synchronous to clk
//  right        in   1   button
//  up           in   1   button
//  down         in   1   button
//  pixel_x      in   11  current scan column from the VGA sync generator
//  pixel_y      in   10  current scan row
//  pos_x        out  11  sprite top-left X, registered
//  pos_y        out  10  sprite top-left Y, registered
//  direction    out  3   000 IDLE, 001 LEFT, 010 RIGHT, 011 UP, 100 DOWN
//  move_strobe  out  1   one-cycle pulse in the cycle after pos_x/pos_y change
//  frame_tick   out  1   one-cycle pulse per frame, for downstream logic
// BEHAVIOUR
//  Reset (async assert, sync release):
//   pos_x=INIT_X, pos_y=INIT_Y, direction=IDLE, move_strobe=0, frame_tick=0,
//   frame counter=0, edge register=0.
//  Direction FSM (registered, every clk):
//   - Next state follows the buttons. Priority is UP > DOWN > LEFT > RIGHT.
//   - No button pressed -> IDLE.
//   - Any state can go to any state in one cycle.
//  frame_tick:
//   - eof = (pixel_x==H_LAST && pixel_y==V_LAST).
//   - frame_tick=1 in the cycle after eof rises, i.e. when eof is set and eof_q is clear.
//   - It fires exactly once per frame, even when a pixel is held for several clk cycles.
//  Frame divider:
//   - On each frame_tick, the counter increments.
//   - At FRAME_DIV-1 it wraps to 0 and asserts upd for that cycle.
//   - FRAME_DIV=1 gives upd=frame_tick.
//  Update (on upd, using direction as registered at that cycle):
//   - LEFT: x-=STEP. RIGHT: x+=STEP. UP: y-=STEP (screen-up). DOWN: y+=STEP.
//   - IDLE: no change and no move_strobe.
//   - Arithmetic is 1 bit wider, signed, to detect underflow and overflow.
//   - Legal X range: 0..H_LAST+1-SPRITE_W. Legal Y range: 0..V_LAST+1-SPRITE_H.
//   - WRAP=0: the result saturates at the range limit. If the position is already at
//     the limit, nothing changes and move_strobe stays 0.
//   - WRAP=1: leaving past the max goes to 0. Leaving past 0 goes to the max.
//     STEP overshoot is discarded, not carried.
//   - move_strobe=1 the cycle after any actual change of pos_x or pos_y.
//  Simultaneous events:
//   - A button change in the same cycle as upd has no effect on that update; the FSM
//     value before the edge is used.
//   - Reset mid-frame restarts the divider. The first frame_tick then needs eof to rise
//     again.
// STRUCTURE
//  Package sprite_motion_pkg:
//   - direction encodings (DIR_IDLE..DIR_DOWN)
//   - default screen constants H_LAST/V_LAST
//   - shared with the spriteMoveFSM consumers
//  Sub-module frame_tick_gen: eof compare, edge detect and FRAME_DIV counter;
//   outputs frame_tick and upd.
//  Top: direction FSM, position datapath with clamp/wrap, strobe register.
// TESTING
//  1. Reset low mid-run -> pos=(50,300), direction=000, strobes 0, immediately (async).
//  2. Hold right, 3 frames, STEP=1 -> pos_x 50->53; one move_strobe per frame; pos_y=300.
//  3. Press up+left together -> direction=011; after 1 frame pos_y=299, pos_x unchanged.
//  4. WRAP=0, pos_x=774, hold right, STEP=4 -> 775, then stays 775; move_strobe only once.
//  5. WRAP=1, pos_y=1, hold up, STEP=2 -> pos_y=575 after one frame.
//  6. FRAME_DIV=4, pixel held 3 clk per pixel, hold down, 8 frames -> 8 frame_ticks, pos_y=302.

Source files
------------

// File: rtl/sprite_motion_pkg.sv
// Shared sprite-motion definitions: direction encodings, default screen limits and
// the button-to-direction priority decode used by the motion FSM and its consumers.
package sprite_motion_pkg;

  typedef enum logic [2:0] {
    DIR_IDLE  = 3'b000,
    DIR_LEFT  = 3'b001,
    DIR_RIGHT = 3'b010,
    DIR_UP    = 3'b011,
    DIR_DOWN  = 3'b100
  } dir_e;

  localparam int H_LAST_DEF = 799;
  localparam int V_LAST_DEF = 599;

  // Vertical buttons win over horizontal ones so diagonal presses move on Y only.
  function automatic dir_e dir_from_buttons(input logic left, input logic right,
                                            input logic up, input logic down);
    if (up)         return DIR_UP;
    else if (down)  return DIR_DOWN;
    else if (left)  return DIR_LEFT;
    else if (right) return DIR_RIGHT;
    else            return DIR_IDLE;
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// End-of-frame detector: one registered frame_tick per frame (even with held pixels)
// and an update enable every FRAME_DIV frames.
module frame_tick_gen #(
  parameter int H_LAST    = 799,
  parameter int V_LAST    = 599,
  parameter int FRAME_DIV = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] pixel_x_i,
  input  logic [9:0]  pixel_y_i,
  output logic        frame_tick_o,
  output logic        upd_o
);

  localparam logic [7:0] CNT_LAST = 8'(FRAME_DIV - 1);

  logic       eof;
  logic       eof_q;
  logic       tick_q;
  logic [7:0] cnt_q;

  assign eof = (pixel_x_i == 11'(H_LAST)) && (pixel_y_i == 10'(V_LAST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eof_q  <= 1'b0;
      tick_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      eof_q  <= eof;
      tick_q <= eof && !eof_q;
      if (tick_q) begin
        cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + 8'd1;
      end
    end
  end

  assign frame_tick_o = tick_q;
  assign upd_o        = tick_q && (cnt_q == CNT_LAST);

endmodule

// File: rtl/sprite_motion_ctrl.sv
// Sprite motion controller: button-driven direction FSM and a position register that
// steps once per FRAME_DIV frames, clamping or wrapping at the screen edges.
module sprite_motion_ctrl
  import sprite_motion_pkg::*;
#(
  parameter int H_LAST    = H_LAST_DEF,
  parameter int V_LAST    = V_LAST_DEF,
  parameter int INIT_X    = 50,
  parameter int INIT_Y    = 300,
  parameter int SPRITE_W  = 25,
  parameter int SPRITE_H  = 25,
  parameter int STEP      = 1,
  parameter int FRAME_DIV = 1,
  parameter bit WRAP      = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        left,
  input  logic        right,
  input  logic        up,
  input  logic        down,
  input  logic [10:0] pixel_x,
  input  logic [9:0]  pixel_y,
  output logic [10:0] pos_x,
  output logic [9:0]  pos_y,
  output logic [2:0]  direction,
  output logic        move_strobe,
  output logic        frame_tick
);

  localparam int X_MAX = H_LAST + 1 - SPRITE_W;
  localparam int Y_MAX = V_LAST + 1 - SPRITE_H;
  localparam logic signed [11:0] X_MAX_S  = 12'(X_MAX);
  localparam logic signed [10:0] Y_MAX_S  = 11'(Y_MAX);
  localparam logic signed [11:0] STEP_XS  = 12'(STEP);
  localparam logic signed [10:0] STEP_YS  = 11'(STEP);

  dir_e               dir_q;
  logic [10:0]        pos_x_q, pos_x_d;
  logic [9:0]         pos_y_q, pos_y_d;
  logic               strobe_q;
  logic               upd;
  logic               changed;
  logic signed [11:0] x_sum;
  logic signed [10:0] y_sum;

  frame_tick_gen #(
    .H_LAST   (H_LAST),
    .V_LAST   (V_LAST),
    .FRAME_DIV(FRAME_DIV)
  ) u_tick (
    .clk         (clk),
    .rst_n       (reset),
    .pixel_x_i   (pixel_x),
    .pixel_y_i   (pixel_y),
    .frame_tick_o(frame_tick),
    .upd_o       (upd)
  );

  // One bit of headroom makes underflow show up as a negative sum.
  always_comb begin
    x_sum = signed'({1'b0, pos_x_q});
    y_sum = signed'({1'b0, pos_y_q});
    case (dir_q)
      DIR_LEFT:  x_sum = x_sum - STEP_XS;
      DIR_RIGHT: x_sum = x_sum + STEP_XS;
      DIR_UP:    y_sum = y_sum - STEP_YS;
      DIR_DOWN:  y_sum = y_sum + STEP_YS;
      default:   ;
    endcase

    if (x_sum < 12'sd0)        pos_x_d = WRAP ? 11'(X_MAX) : 11'd0;
    else if (x_sum > X_MAX_S)  pos_x_d = WRAP ? 11'd0 : 11'(X_MAX);
    else                       pos_x_d = x_sum[10:0];

    if (y_sum < 11'sd0)        pos_y_d = WRAP ? 10'(Y_MAX) : 10'd0;
    else if (y_sum > Y_MAX_S)  pos_y_d = WRAP ? 10'd0 : 10'(Y_MAX);
    else                       pos_y_d = y_sum[9:0];

    changed = (pos_x_d != pos_x_q) || (pos_y_d != pos_y_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      dir_q    <= DIR_IDLE;
      pos_x_q  <= 11'(INIT_X);
      pos_y_q  <= 10'(INIT_Y);
      strobe_q <= 1'b0;
    end else begin
      dir_q    <= dir_from_buttons(left, right, up, down);
      strobe_q <= upd && changed;
      if (upd) begin
        pos_x_q <= pos_x_d;
        pos_y_q <= pos_y_d;
      end
    end
  end

  assign pos_x       = pos_x_q;
  assign pos_y       = pos_y_q;
  assign direction   = dir_q;
  assign move_strobe = strobe_q;

endmodule
